// File: rtl/gf16_pkg.sv
// gf16_pkg: shared widths, field polynomial and FSM encoding
// for the GF(2^16) polynomial-hash engine.
package gf16_pkg;

    localparam int GF_W = 16;

    // Low terms of P(x) = x^16 + x^12 + x^3 + x + 1
    localparam logic [GF_W-1:0] POLY = 16'h100B;

    typedef enum logic [1:0] {
        ACCEPT,
        ISSUE,
        REDUCE,
        OUT
    } state_t;

endpackage

// File: rtl/gf16_reduce.sv
// gf16_reduce: combinational reduction of a carry-less product
// modulo P(x), reusable by any GF(2^16) stage.
module gf16_reduce
    import gf16_pkg::*;
(
    input  logic [2*GF_W-1:0] z,
    output logic [GF_W-1:0]   r
);

    localparam logic [2*GF_W-1:0] PFULL = {15'd0, 1'b1, POLY};

    logic [2*GF_W-1:0] t;

    // Clear bits top-down so every overflow term is folded back in.
    always_comb begin
        t = z;
        t[2*GF_W-1] = 1'b0;
        for (int i = 2*GF_W-2; i >= GF_W; i--) begin
            if (t[i]) begin
                t = t ^ (PFULL << (i - GF_W));
            end
        end
        r = t[GF_W-1:0];
    end

endmodule

// File: rtl/gf16_hash.sv
// gf16_hash: GHASH-style accumulator acc <- ((acc ^ word) * H) mod P
// driving an external registered carry-less multiplier.
module gf16_hash
    import gf16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    input  logic [GF_W-1:0]   key_data,
    output logic              key_ready,
    input  logic              in_valid,
    input  logic [GF_W-1:0]   in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [GF_W-1:0]   out_data,
    input  logic              out_ready,
    output logic [GF_W-1:0]   mul_x,
    output logic [GF_W-1:0]   mul_y,
    input  logic [2*GF_W-1:0] mul_z
);

    state_t          state;
    logic [GF_W-1:0] h_r;
    logic [GF_W-1:0] acc;
    logic [GF_W-1:0] word_r;
    logic            key_ok;
    logic            last_r;
    logic            msg_open;
    logic [GF_W-1:0] red;

    gf16_reduce u_reduce (
        .z (mul_z),
        .r (red)
    );

    // Handshake and operand outputs decode flops only.
    assign key_ready = (state == ACCEPT) && !msg_open;
    assign in_ready  = (state == ACCEPT) && key_ok;
    assign out_valid = (state == OUT);
    assign out_data  = out_valid ? acc : '0;
    assign mul_x     = (state == ISSUE) ? (acc ^ word_r) : '0;
    assign mul_y     = (state == ISSUE) ? h_r : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACCEPT;
            h_r      <= '0;
            key_ok   <= 1'b0;
            acc      <= '0;
            word_r   <= '0;
            last_r   <= 1'b0;
            msg_open <= 1'b0;
        end else begin
            if (key_valid && key_ready) begin
                h_r    <= key_data;
                key_ok <= 1'b1;
            end
            unique case (state)
                ACCEPT: begin
                    if (in_valid && in_ready) begin
                        word_r   <= in_data;
                        last_r   <= in_last;
                        msg_open <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= REDUCE;
                end
                REDUCE: begin
                    acc   <= red;
                    state <= last_r ? OUT : ACCEPT;
                end
                OUT: begin
                    if (out_ready) begin
                        acc      <= '0;
                        msg_open <= 1'b0;
                        state    <= ACCEPT;
                    end
                end
                default: begin
                    state <= ACCEPT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf16_hash.sv
// tb_gf16_hash: vector table, corner sequences and random messages
// against a field-arithmetic reference model.
module tb_gf16_hash;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [15:0] key_data = '0;
    logic        key_ready;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;
    logic [15:0] mul_x;
    logic [15:0] mul_y;
    logic [31:0] mul_z = '0;

    int checks = 0;
    int failures = 0;

    gf16_hash dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_data  (key_data),
        .key_ready (key_ready),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_z     (mul_z)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] clmul(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p = '0;
        for (int i = 0; i < 16; i++)
            if (b[i]) p = p ^ ({16'd0, a} << i);
        return p;
    endfunction

    // External multiplier: registers operands, product one cycle later.
    always @(posedge clk) mul_z <= clmul(mul_x, mul_y);

    // Reference: shift-and-add field multiply, reducing every step.
    function automatic logic [15:0] gf_mul(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r = '0;
        logic [15:0] s = a;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) r = r ^ s;
            s = s[15] ? ((s << 1) ^ 16'h100B) : (s << 1);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_key(input logic [15:0] k);
        int n = 0;
        key_valid = 1'b1;
        key_data  = k;
        @(negedge clk);
        while (!key_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("key_ready_wait", key_ready, 1);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(input int delay, output logic [15:0] d);
        int n = 0;
        out_ready = 1'b0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_wait", out_valid, 1);
        repeat (delay) @(negedge clk);
        d = out_data;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [15:0]      key;
        int               n;
        logic [2:0][15:0] w;
        logic [15:0]      exp;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] k, input int n,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] e);
        vec_t v;
        v.key  = k;
        v.n    = n;
        v.w[0] = a;
        v.w[1] = b;
        v.w[2] = '0;
        v.exp  = e;
        return v;
    endfunction

    vec_t vt[5];

    initial begin
        logic [15:0] d;
        logic [15:0] k;
        logic [15:0] exp;
        logic [15:0] w[$];

        vt[0] = mk(16'h0002, 1, 16'h8000, 16'h0000, 16'h100B);
        vt[1] = mk(16'h0001, 2, 16'h1234, 16'h00FF, 16'h12CB);
        vt[2] = mk(16'h8000, 1, 16'h8000, 16'h0000, 16'h8EFA);
        vt[3] = mk(16'h0003, 1, 16'h0005, 16'h0000, 16'h000F);
        vt[4] = mk(16'h0001, 1, 16'hFFFF, 16'h0000, 16'hFFFF);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_key_ready", key_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_mul_x", mul_x, 0);
        chk("rst_mul_y", mul_y, 0);

        // No key yet: words must be refused and the multiplier stays idle.
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        repeat (4) begin
            @(negedge clk);
            chk("nokey_in_ready", in_ready, 0);
            chk("nokey_mul_x", mul_x, 0);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            load_key(vt[i].key);
            for (int j = 0; j < vt[i].n; j++)
                push_word(vt[i].w[j], j == vt[i].n - 1);
            get_result(0, d);
            chk($sformatf("vec%0d", i), d, vt[i].exp);
        end

        // Latency, backpressure and a mid-message key that must be ignored.
        load_key(16'h0002);
        push_word(16'h8000, 1'b1);
        @(negedge clk);
        chk("issue_mul_x", mul_x, 16'h8000);
        chk("issue_mul_y", mul_y, 16'h0002);
        chk("issue_out_valid", out_valid, 0);
        @(negedge clk);
        chk("reduce_out_valid", out_valid, 0);
        chk("reduce_mul_x", mul_x, 0);
        @(negedge clk);
        chk("lat_out_valid", out_valid, 1);
        chk("lat_out_data", out_data, 16'h100B);
        key_valid = 1'b1;
        key_data  = 16'hFFFF;
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, 16'h100B);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_key_ready", key_ready, 0);
        end
        key_valid = 1'b0;
        get_result(0, d);
        chk("bp_result", d, 16'h100B);
        push_word(16'h8000, 1'b1);
        get_result(0, d);
        chk("after_bp_result", d, 16'h100B);

        // Key and first word on the same edge: word uses the new key.
        key_valid = 1'b1;
        key_data  = 16'h8000;
        in_valid  = 1'b1;
        in_data   = 16'h8000;
        in_last   = 1'b1;
        @(negedge clk);
        chk("same_key_ready", key_ready, 1);
        chk("same_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        get_result(0, d);
        chk("same_edge_result", d, 16'h8EFA);

        // Reset during REDUCE of the last word of a 3-word message.
        k = 16'hA5C3;
        w = '{16'h1357, 16'h2468, 16'hF00D};
        exp = '0;
        foreach (w[i]) exp = gf_mul(exp ^ w[i], k);
        load_key(k);
        push_word(w[0], 1'b0);
        push_word(w[1], 1'b0);
        push_word(w[2], 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out_data", out_data, 0);
        chk("mrst_in_ready", in_ready, 0);
        chk("mrst_key_ready", key_ready, 1);
        chk("mrst_mul_x", mul_x, 0);
        chk("mrst_mul_y", mul_y, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load_key(k);
        push_word(w[0], 1'b0);
        push_word(w[1], 1'b0);
        push_word(w[2], 1'b1);
        get_result(1, d);
        chk("post_rst_result", d, exp);

        // Random messages with gaps, key reloads and output stalls.
        k = 16'h0001;
        for (int m = 0; m < 25; m++) begin
            if (m == 0 || $urandom_range(2) == 0) begin
                k = 16'($urandom);
                load_key(k);
            end
            w.delete();
            for (int j = 0; j < int'($urandom_range(5, 1)); j++)
                w.push_back(16'($urandom));
            exp = '0;
            foreach (w[i]) exp = gf_mul(exp ^ w[i], k);
            foreach (w[i]) begin
                push_word(w[i], i == w.size() - 1);
                repeat ($urandom_range(1)) @(posedge clk);
                #1;
            end
            get_result(int'($urandom_range(3)), d);
            chk($sformatf("rand%0d", m), d, exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
